// File: rtl/mem_access_unit.sv
// Memory access unit: turns a single-word core request into a req/ack memory
// transaction with a timeout, stalls the core while it is outstanding and
// reports misaligned or timed-out accesses.
module mem_access_unit #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_busy,
    output logic              core_done,
    output logic              core_err,
    output logic [DATA_W-1:0] core_rdata,
    output logic [7:0]        err_count,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] counter;
    logic          err_flag;

    assign core_busy = (state == REQ);
    assign core_done = (state == RESP);
    assign core_err  = (state == RESP) && err_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            err_flag   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rdata <= '0;
            err_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_req) begin
                        if (core_addr[1:0] == 2'b00) begin
                            mem_req   <= 1'b1;
                            mem_we    <= core_we;
                            mem_addr  <= core_addr;
                            mem_wdata <= core_wdata;
                            counter   <= '0;
                            err_flag  <= 1'b0;
                            state     <= REQ;
                        end else begin
                            // Misaligned: report immediately, memory is never touched.
                            err_flag <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end
                REQ: begin
                    // Ack is checked first so an ack on the last cycle still succeeds.
                    if (mem_ack) begin
                        if (!mem_we) begin
                            core_rdata <= mem_rdata;
                        end
                        err_flag <= 1'b0;
                        mem_req  <= 1'b0;
                        state    <= RESP;
                    end else if (counter == LAST) begin
                        err_flag <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= RESP;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                RESP: begin
                    if (err_flag && (err_count != 8'hFF)) begin
                        err_count <= err_count + 8'd1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// transactions checked against a transaction-level reference model.
module tb_mem_access_unit;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;

    logic              clk;
    logic              rst;
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_busy;
    logic              core_done;
    logic              core_err;
    logic [DATA_W-1:0] core_rdata;
    logic [7:0]        err_count;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    mem_access_unit #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .core_req  (core_req),
        .core_we   (core_we),
        .core_addr (core_addr),
        .core_wdata(core_wdata),
        .core_busy (core_busy),
        .core_done (core_done),
        .core_err  (core_err),
        .core_rdata(core_rdata),
        .err_count (err_count),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: last successful read data and error tally.
    logic [DATA_W-1:0] exp_rdata;
    int                exp_errcnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            step();
            check("idle_done", core_done, 0);
            check("idle_req", mem_req, 0);
            check("idle_busy", core_busy, 0);
            check("idle_rdata", core_rdata, exp_rdata);
            check("idle_errcnt", err_count, exp_errcnt);
        end
        mem_ack = 1'b0;
    endtask

    // One core access; delay = REQ cycle index of the ack, >= TIMEOUT means never.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int delay, input logic [31:0] rdata);
        bit err;
        core_req   = 1'b1;
        core_we    = we;
        core_addr  = addr;
        core_wdata = wdata;
        mem_ack    = 1'b0;
        step();
        core_req = 1'b0;
        if (addr[1:0] != 2'b00) begin
            check("mis_req", mem_req, 0);
            check("mis_busy", core_busy, 0);
            check("mis_done", core_done, 1);
            check("mis_err", core_err, 1);
            err = 1'b1;
        end else begin
            for (int k = 0; k < int'(TIMEOUT); k++) begin
                check("req_mem_req", mem_req, 1);
                check("req_busy", core_busy, 1);
                check("req_done", core_done, 0);
                check("req_addr", mem_addr, addr);
                check("req_we", mem_we, we);
                if (we) check("req_wdata", mem_wdata, wdata);
                core_req   = 1'($urandom_range(0, 1));
                core_we    = 1'($urandom_range(0, 1));
                core_addr  = $urandom;
                core_wdata = $urandom;
                mem_ack    = (k == delay);
                mem_rdata  = (k == delay) ? rdata : 32'($urandom);
                step();
                if (k == delay) break;
            end
            core_req = 1'b0;
            mem_ack  = 1'b0;
            err = (delay < 0) || (delay >= int'(TIMEOUT));
            check("resp_done", core_done, 1);
            check("resp_err", core_err, err);
            check("resp_req", mem_req, 0);
            check("resp_busy", core_busy, 0);
        end
        if (!err && !we) exp_rdata = rdata;
        if (err && exp_errcnt < 255) exp_errcnt++;
        check("resp_rdata", core_rdata, exp_rdata);
        step();
        check("post_done", core_done, 0);
        check("post_errcnt", err_count, exp_errcnt);
        check("post_rdata", core_rdata, exp_rdata);
    endtask

    initial begin
        rst        = 1'b1;
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        exp_rdata  = '0;
        exp_errcnt = 0;

        // Reset then idle
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_req", mem_req, 0);
            check("rst_done", core_done, 0);
            check("rst_busy", core_busy, 0);
            check("rst_err", core_err, 0);
            check("rst_we", mem_we, 0);
            check("rst_addr", mem_addr, 0);
            check("rst_wdata", mem_wdata, 0);
            check("rst_rdata", core_rdata, 0);
            check("rst_errcnt", err_count, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle0_req", mem_req, 0);
            check("idle0_done", core_done, 0);
            check("idle0_err", core_err, 0);
            check("idle0_busy", core_busy, 0);
            check("idle0_addr", mem_addr, 0);
            check("idle0_rdata", core_rdata, 0);
        end

        // Directed scenarios
        do_access(1'b0, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF);
        do_access(1'b1, 32'h0000_0020, 32'h1234_5678, 3, 32'hFFFF_0000);
        do_access(1'b0, 32'h0000_0013, 32'h0, 0, 32'h5555_5555);
        do_access(1'b0, 32'h0000_0040, 32'h0, int'(TIMEOUT), 32'hAAAA_AAAA);
        do_access(1'b0, 32'h0000_0044, 32'h0, int'(TIMEOUT) - 1, 32'hCAFE_F00D);
        idle_cycles(2);

        // Reset in the 2nd REQ cycle, with an ack pending
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 32'h0000_0080;
        step();
        core_req = 1'b0;
        step();
        check("mid_busy", core_busy, 1);
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        step();
        rst     = 1'b0;
        mem_ack = 1'b0;
        exp_rdata  = '0;
        exp_errcnt = 0;
        check("mid_req", mem_req, 0);
        check("mid_done", core_done, 0);
        check("mid_rdata", core_rdata, 0);
        check("mid_errcnt", err_count, 0);
        idle_cycles(3);

        // Random traffic
        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            int d;
            a = $urandom;
            if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
            d = ($urandom_range(0, 7) == 0) ? int'(TIMEOUT) : int'($urandom_range(0, TIMEOUT - 1));
            do_access(1'($urandom_range(0, 1)), a, $urandom, d, $urandom);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        // Saturation of the error counter
        for (int t = 0; t < 260; t++) begin
            logic [31:0] a;
            a = $urandom;
            a[1:0] = 2'($urandom_range(1, 3));
            do_access(1'($urandom_range(0, 1)), a, $urandom, 0, $urandom);
        end
        check("sat_errcnt", err_count, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory access unit for the multicycle RISC-V core: sits directly downstream of the control FSM and datapath address mux. It turns a single-word core request (the address selected by AdrSrc, the MemWrite strobe, and the write data) into a req/ack transaction on a variable-latency memory port. It returns registered read data to the instruction and data registers, and stalls the core while the transaction is outstanding. Misaligned addresses and memory timeouts are reported as errors.

## Interface
Parameters:
- ADDR_W, 32, core and memory address width
- DATA_W, 32, data width (one word per access)
- TIMEOUT, 16, maximum REQ cycles without mem_ack before abort (≥2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- core_req  in  1  access request; sampled only in IDLE
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  byte address; must be word-aligned
- core_wdata  in  DATA_W  write data
- core_busy  out  1  high while in REQ; control FSM must hold its state
- core_done  out  1  one-cycle completion pulse
- core_err  out  1  valid with core_done; 1 = misaligned or timeout
- core_rdata  out  DATA_W  registered read data; holds last successful read
- err_count  out  8  saturating count of errored accesses
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  registered word address (byte address, [1:0]=0)
- mem_wdata  out  DATA_W  registered write data
- mem_ack  in  1  memory completion; read data valid in same cycle
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, REQ, RESP. Timeout counter is clog2(TIMEOUT) bits wide. There is also an err_flag register.
- IDLE:
  - core_req=1 and core_addr[1:0]==0: latch addr/we/wdata into mem_* registers, clear counter and err_flag, go to REQ.
  - core_req=1 and core_addr[1:0]!=0: set err_flag, go to RESP. No mem_req is issued.
  - core_req=0: stay in IDLE.
- REQ:
  - mem_req=1, and mem_addr/mem_we/mem_wdata are held stable.
  - mem_ack=1: if read, load core_rdata←mem_rdata; go to RESP with err_flag=0.
  - No ack and counter==TIMEOUT-1: set err_flag, go to RESP. The memory abort is implied by mem_req dropping.
  - Otherwise: counter+1.
- RESP: core_done=1, core_err=err_flag. If err_flag=1, err_count increments, saturating at 255. Then go to IDLE unconditionally.
- core_req during REQ or RESP is ignored; the core re-presents it in IDLE.
- mem_ack outside REQ is ignored and has no side effects.
- A write, or any errored access, never modifies core_rdata.

## Timing
- Reset values:
  - state=IDLE, counter=0, err_flag=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - core_busy=0, core_done=0, core_err=0, core_rdata=0, err_count=0.
- Output derivation:
  - core_busy = (state==REQ), combinational from state.
  - core_done and core_err are decoded from state RESP.
  - mem_req is high exactly while state==REQ.
- Minimum latency: request accepted at cycle 0 and ack in the first REQ cycle (cycle 1) gives core_done at cycle 2, with core_rdata valid from cycle 2. The next request is accepted at cycle 3 at the earliest.
- Ack arriving k cycles after REQ entry (k=0..TIMEOUT-1) puts core_done at cycle 2+k.
- Timeout: with no ack, REQ lasts exactly TIMEOUT cycles, and core_done with core_err=1 occurs at cycle TIMEOUT+1.
- Ack in the final REQ cycle, coincident with the timeout condition: ack wins, the access succeeds, and err_flag stays 0.
- Misaligned: core_done with core_err=1 at cycle 1; mem_req is never asserted.
- rst during REQ: mem_req=0 on the next cycle, no core_done is generated, core_rdata clears to 0, and a pending ack is dropped.
- rst has priority over all transitions.

## Test plan
- Reset then idle:
  - Stimulus: hold rst 2 cycles, release, keep core_req=0 for 5 cycles.
  - Required response: all outputs 0 throughout; mem_req never asserts.
- Read with zero-wait memory:
  - Stimulus: read addr 0x0000_0010; memory acks in the first REQ cycle with 0xDEAD_BEEF.
  - Required response: mem_req high for 1 cycle with mem_addr=0x10; core_done at cycle 2; core_rdata=0xDEAD_BEEF; core_err=0.
- Write with 3-cycle wait:
  - Stimulus: write 0x1234_5678 to 0x20; mem_ack arrives 3 cycles into REQ.
  - Required response: mem_we=1; addr/data stable for 4 REQ cycles; core_busy high for those 4 cycles; core_done at cycle 5; core_rdata unchanged.
- Misaligned access:
  - Stimulus: read addr 0x0000_0013.
  - Required response: core_done and core_err=1 at cycle 1; mem_req stays 0; err_count=1.
- Timeout and coincident ack, TIMEOUT=16:
  - Stimulus A: no ack.
  - Required response A: core_err=1 at cycle 17; err_count increments.
  - Stimulus B: repeat with ack in REQ cycle 16.
  - Required response B: core_err=0 and read data is captured.
- Reset mid-transaction and saturation:
  - Stimulus A: assert rst in the 2nd REQ cycle.
  - Required response A: mem_req=0 next cycle; no core_done.
  - Stimulus B: issue 260 misaligned requests.
  - Required response B: err_count=255.
